// File: rtl/dispense_ctrl.sv
// dispense_ctrl
// Actuator stage behind the vending transaction FSM. Each non-zero
// {drink_in, refund_in} result is queued in a small FIFO. Queued entries are
// then played out one at a time: the drink motor runs for a fixed time, and
// then the refund coins are ejected one pulse at a time.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   drink_in    drink code from the FSM (00 none, 01 water, 10 coke, 11 coffee)
//   refund_in   coins to return, 0..3
//   motor_en    dispense motor drive
//   motor_sel   drink code being dispensed, 00 when the motor is off
//   coin_eject  coin ejector solenoid
//   busy        FIFO non-empty or state not IDLE
//   fifo_count  number of queued entries
//   overflow    sticky, set when a request is dropped on a full FIFO
//   cur_state   00 IDLE, 01 DISPENSE, 10 EJECT_HI, 11 EJECT_LO
//
// state    | meaning
// IDLE     | waiting; pops the FIFO head when one is queued
// DISPENSE | motor on for MOTOR_CYCLES cycles
// EJECT_HI | ejector on for EJECT_HIGH cycles, one coin
// EJECT_LO | gap of EJECT_GAP cycles after each coin
module dispense_ctrl #(
  parameter int DEPTH        = 4,
  parameter int MOTOR_CYCLES = 8,
  parameter int EJECT_HIGH   = 2,
  parameter int EJECT_GAP    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 drink_in,
  input  logic [1:0]                 refund_in,
  output logic                       motor_en,
  output logic [1:0]                 motor_sel,
  output logic                       coin_eject,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [1:0]                 cur_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_DISPENSE = 2'b01;
  localparam logic [1:0] S_EJECT_HI = 2'b10;
  localparam logic [1:0] S_EJECT_LO = 2'b11;

  localparam logic [7:0] LD_MOTOR = 8'(MOTOR_CYCLES);
  localparam logic [7:0] LD_HIGH  = 8'(EJECT_HIGH);
  localparam logic [7:0] LD_GAP   = 8'(EJECT_GAP);

  logic [3:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;

  logic [1:0] state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] drink_r, drink_n;
  logic [1:0] refund_r, refund_n;
  logic       overflow_r;

  logic       req, pop, push;
  logic [3:0] head;

  assign req  = (drink_in != 2'b00) || (refund_in != 2'b00);
  // Pop is based on the registered count, so a request is never consumed in
  // the same cycle it is written; this gives the one-cycle actuation latency.
  assign pop  = (state == S_IDLE) && (count != '0);
  assign push = req && ((count != FULL) || pop);
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (push && !pop)
      count_n = count + CW'(1);
    else if (!push && pop)
      count_n = count - CW'(1);
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    drink_n  = drink_r;
    refund_n = refund_r;
    case (state)
      S_IDLE: begin
        if (pop) begin
          drink_n  = head[3:2];
          refund_n = head[1:0];
          if (head[3:2] != 2'b00) begin
            state_n = S_DISPENSE;
            cnt_n   = LD_MOTOR;
          end else begin
            state_n = S_EJECT_HI;
            cnt_n   = LD_HIGH;
          end
        end
      end
      S_DISPENSE: begin
        if (cnt == 8'd1) begin
          drink_n = 2'b00;
          if (refund_r != 2'b00) begin
            state_n = S_EJECT_HI;
            cnt_n   = LD_HIGH;
          end else begin
            state_n = S_IDLE;
            cnt_n   = 8'd0;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_EJECT_HI: begin
        if (cnt == 8'd1) begin
          refund_n = refund_r - 2'd1;
          state_n  = S_EJECT_LO;
          cnt_n    = LD_GAP;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_EJECT_LO: begin
        if (cnt == 8'd1) begin
          if (refund_r != 2'b00) begin
            state_n = S_EJECT_HI;
            cnt_n   = LD_HIGH;
          end else begin
            state_n = S_IDLE;
            cnt_n   = 8'd0;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // Storage needs no reset: only entries between rd_ptr and wr_ptr are read.
  always_ff @(posedge clk) begin
    if (!rst && push)
      fifo_mem[wr_ptr] <= {drink_in, refund_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_IDLE;
      cnt        <= 8'd0;
      drink_r    <= 2'b00;
      refund_r   <= 2'b00;
      overflow_r <= 1'b0;
      motor_en   <= 1'b0;
      motor_sel  <= 2'b00;
      coin_eject <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (req && !push)
        overflow_r <= 1'b1;
      count    <= count_n;
      state    <= state_n;
      cnt      <= cnt_n;
      drink_r  <= drink_n;
      refund_r <= refund_n;
      // Decoded from the next state so actuators switch with cur_state.
      motor_en   <= (state_n == S_DISPENSE);
      motor_sel  <= (state_n == S_DISPENSE) ? drink_n : 2'b00;
      coin_eject <= (state_n == S_EJECT_HI);
      busy       <= (state_n != S_IDLE) || (count_n != '0);
    end
  end

  assign fifo_count = count;
  assign overflow   = overflow_r;
  assign cur_state  = state;

endmodule
